// File: rtl/dcm_prog_ctrl.sv
// Push-button driven programming controller for a DCM/clock generator: debounces a press and
// emits one update strobe with a rate code. Optional build macro STEP_MODE_EN steps the code.
module dcm_prog_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button,
  input  logic [2:0] switches,
  output logic       update,
  output logic [2:0] prog_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StFire,
    StHold
  } state_e;

  localparam logic [31:0] CntMax = 32'(DEBOUNCE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        update_q, update_d;
  logic [2:0]  prog_sel_q, prog_sel_d;
  logic        busy_q, busy_d;

  logic        btn_m_q, btn_s_q;
  logic [2:0]  load_sel;

  // Button synchronizer
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_m_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      btn_m_q <= button;
      btn_s_q <= btn_m_q;
    end
  end

`ifdef STEP_MODE_EN
  // Switches are ignored in step mode; the port stays for a uniform port list.
  logic unused_switches;
  assign unused_switches = ^switches;
  assign load_sel        = prog_sel_q + 3'd1;
`else
  logic [2:0] sw_m_q, sw_s_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sw_m_q <= 3'b000;
      sw_s_q <= 3'b000;
    end else begin
      sw_m_q <= switches;
      sw_s_q <= sw_m_q;
    end
  end

  assign load_sel = sw_s_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      update_q   <= 1'b0;
      prog_sel_q <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      update_q   <= update_d;
      prog_sel_q <= prog_sel_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    update_d   = 1'b0;
    prog_sel_d = prog_sel_q;

    case (state_q)
      StIdle: begin
        if (btn_s_q) begin
          state_d = StDebounce;
          cnt_d   = '0;
        end
      end
      StDebounce: begin
        if (!btn_s_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          // Strobe and rate code leave the flops on the same edge.
          state_d    = StFire;
          update_d   = 1'b1;
          prog_sel_d = load_sel;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFire: begin
        state_d = StHold;
        cnt_d   = '0;
      end
      StHold: begin
        // Any high sample restarts the release qualification.
        if (btn_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  assign update   = update_q;
  assign prog_sel = prog_sel_q;
  assign busy     = busy_q;

endmodule
